// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port data memory with a fixed-latency request /
// acknowledge handshake. Each access runs IDLE -> ACCESS -> RESP -> IDLE, so a
// request sampled in cycle N is acknowledged in cycle N+2.
//
// Optional build macro: DMEM_MISALIGN_CHK_EN
//   defined   : misaligned half/word accesses are suppressed and flagged on err
//   undefined : err is always 0; halves ignore addr[0], words ignore addr[1:0]
//
// Ports
//   adc_sck  in   1   clock, rising edge
//   reset    in   1   synchronous, active-high
//   req      in   1   access request (sampled only in IDLE)
//   we       in   1   1 = store, 0 = load
//   store    in   2   size: 00 word, 01 half, 10 byte, 11 word
//   addr     in   32  byte address (wraps modulo 4*DEPTH)
//   wdata    in   32  right-aligned store data
//   rdata    out  32  aligned word from the last load
//   ack      out  1   one-cycle completion pulse
//   busy     out  1   high while not in IDLE
//   err      out  1   misalignment flag, valid with ack
module data_mem_responder #(
  parameter int unsigned DEPTH = 64
) (
  input  logic        adc_sck,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  logic          we_q;
  logic [1:0]    store_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx;
  logic [3:0]    lane_en;
  logic [31:0]   wdata_lanes;
  logic          misaligned;
  logic          commit;

  // Address bits above the storage range are deliberately ignored (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:AW+2];

  always_comb begin
    idx         = addr_q[AW+1:2];
    lane_en     = 4'b1111;
    wdata_lanes = wdata_q;
    case (store_q)
      2'b01: begin
        lane_en     = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        lane_en     = 4'b0001 << addr_q[1:0];
        wdata_lanes = {4{wdata_q[7:0]}};
      end
      default: begin
        lane_en     = 4'b1111;
        wdata_lanes = wdata_q;
      end
    endcase
  end

`ifdef DMEM_MISALIGN_CHK_EN
  always_comb begin
    misaligned = ((store_q == 2'b01) && addr_q[0]) ||
                 (((store_q == 2'b00) || (store_q == 2'b11)) && (addr_q[1:0] != 2'b00));
  end
`else
  always_comb begin
    misaligned = 1'b0;
  end
`endif

  // Reset in the ACCESS cycle must suppress the write, hence the !reset term.
  assign commit = (state == ACCESS) && we_q && !misaligned && !reset;

  // Storage is intentionally not reset.
  always_ff @(posedge adc_sck) begin
    if (commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          mem[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge adc_sck) begin
    if (reset) begin
      state   <= IDLE;
      ack     <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      we_q    <= 1'b0;
      store_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          err <= 1'b0;
          if (req) begin
            we_q    <= we;
            store_q <= store;
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
            busy    <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          ack   <= 1'b1;
          err   <= misaligned;
          state <= RESP;
          if (!we_q) begin
            rdata <= misaligned ? '0 : mem[idx];
          end
        end
        RESP: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: byte-array reference model feeding a
// scoreboard queue, plus directed checks for wrap, lanes, held req and reset.
module tb_data_mem_responder;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned NBYTES = 4 * DEPTH;

  logic        adc_sck;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  store;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        err;

  data_mem_responder #(.DEPTH(DEPTH)) dut (
    .adc_sck (adc_sck),
    .reset   (reset),
    .req     (req),
    .we      (we),
    .store   (store),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ack     (ack),
    .busy    (busy),
    .err     (err)
  );

  initial adc_sck = 1'b0;
  always #5 adc_sck = ~adc_sck;

  int cyc = 0;
  always @(posedge adc_sck) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  mem_b [NBYTES];
  logic [31:0] last_rdata;
  int          checks = 0;
  int          passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: memory as a flat byte array, addresses wrap modulo NBYTES.
  task automatic predict(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input int lat);
    int unsigned b, base, n;
    logic        mis;
    exp_t        e;
    b   = a % NBYTES;
    mis = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
    mis = ((sz == 2'd1) && (b % 2 != 0)) || (((sz == 2'd0) || (sz == 2'd3)) && (b % 4 != 0));
`endif
    n    = (sz == 2'd2) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = b - (b % n);
    if (w) begin
      if (!mis)
        for (int unsigned i = 0; i < n; i++) mem_b[base + i] = wd[8*i +: 8];
    end else begin
      base       = b - (b % 4);
      last_rdata = mis ? 32'h0 :
                   {mem_b[base + 3], mem_b[base + 2], mem_b[base + 1], mem_b[base]};
    end
    e.rdata = last_rdata;
    e.err   = mis;
    e.at    = cyc + lat;
    sb.push_back(e);
  endtask

  // Called at posedge+#1 with the DUT idle; returns at posedge+#1, idle again.
  task automatic do_access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd);
    req = 1'b1; we = w; store = sz; addr = a; wdata = wd;
    predict(w, sz, a, wd, 2);
    @(posedge adc_sck); #1;
    req = 1'b0;
    repeat (2) @(posedge adc_sck);
    #1;
  endtask

  // Monitor: every ack must match the head of the scoreboard, on the right cycle.
  always @(negedge adc_sck) begin
    if (ack) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_ack at cycle %0d rdata=%h err=%b", cyc, rdata, err);
      end else begin
        mon_e = sb.pop_front();
        if (rdata === mon_e.rdata && err === mon_e.err && cyc == mon_e.at) passed++;
        else $display("FAIL ack_resp: rdata=%h err=%b cycle=%0d, expected rdata=%h err=%b cycle=%0d",
                      rdata, err, cyc, mon_e.rdata, mon_e.err, mon_e.at);
      end
    end else if (sb.size() != 0 && cyc >= sb[0].at) begin
      checks++;
      mon_e = sb.pop_front();
      $display("FAIL missed_ack: no ack by cycle %0d, expected at cycle %0d", cyc, mon_e.at);
    end
  end

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; store = 2'd0; addr = '0; wdata = '0;
    last_rdata = '0;
    repeat (3) @(posedge adc_sck);
    @(negedge adc_sck);
    check("reset_ack",   {31'd0, ack},  32'd0);
    check("reset_busy",  {31'd0, busy}, 32'd0);
    check("reset_err",   {31'd0, err},  32'd0);
    check("reset_rdata", rdata,         32'd0);
    @(posedge adc_sck); #1;
    reset = 1'b0;

    // Give every word a known value.
    for (int unsigned w = 0; w < DEPTH; w++) do_access(1'b1, 2'd0, w * 4, $urandom);

    // Word store/load.
    do_access(1'b1, 2'd0, 32'h10, 32'hDEADBEEF);
    do_access(1'b0, 2'd0, 32'h10, 32'h0);
    check("word_load", rdata, 32'hDEADBEEF);

    // Byte and half lanes; a store leaves rdata untouched.
    do_access(1'b1, 2'd0, 32'h20, 32'h0);
    do_access(1'b1, 2'd2, 32'h22, 32'hFFFF_FFAB);
    do_access(1'b0, 2'd0, 32'h20, 32'h0);
    check("byte_lane", rdata, 32'h00AB0000);
    do_access(1'b1, 2'd1, 32'h20, 32'hFFFF_1234);
    check("store_keeps_rdata", rdata, 32'h00AB0000);
    do_access(1'b0, 2'd0, 32'h20, 32'h0);
    check("half_lane", rdata, 32'h00AB1234);

    // Wrap-around.
    do_access(1'b1, 2'd0, 32'h104, 32'h55);
    do_access(1'b0, 2'd0, 32'h004, 32'h0);
    check("wrap_load", rdata, 32'h00000055);

    // Held req for 6 cycles: two accesses, acks 3 cycles apart.
    req = 1'b1; we = 1'b0; store = 2'd0; addr = 32'h10; wdata = '0;
    predict(1'b0, 2'd0, 32'h10, 32'h0, 2);
    predict(1'b0, 2'd0, 32'h10, 32'h0, 5);
    for (int i = 1; i <= 6; i++) begin
      @(posedge adc_sck);
      @(negedge adc_sck);
      check($sformatf("held_busy_%0d", i), {31'd0, busy}, {31'd0, (i % 3) != 0});
    end
    req = 1'b0;
    @(posedge adc_sck); #1;

    // Reset during ACCESS aborts the store.
    req = 1'b1; we = 1'b1; store = 2'd0; addr = 32'h30; wdata = 32'hCAFEF00D;
    @(posedge adc_sck); #1;
    req = 1'b0; reset = 1'b1;
    @(posedge adc_sck);
    @(negedge adc_sck);
    check("abort_ack",   {31'd0, ack},  32'd0);
    check("abort_busy",  {31'd0, busy}, 32'd0);
    check("abort_err",   {31'd0, err},  32'd0);
    check("abort_rdata", rdata,         32'd0);
    last_rdata = '0;
    @(posedge adc_sck); #1;
    reset = 1'b0;
    do_access(1'b0, 2'd0, 32'h30, 32'h0);

    // Odd-address half store.
    do_access(1'b1, 2'd0, 32'h40, 32'hA5A5A5A5);
    do_access(1'b1, 2'd1, 32'h41, 32'h00001234);
    do_access(1'b0, 2'd0, 32'h40, 32'h0);
`ifdef DMEM_MISALIGN_CHK_EN
    check("misaligned_half", rdata, 32'hA5A5A5A5);
`else
    check("misaligned_half", rdata, 32'hA5A51234);
`endif

    // Random traffic with occasional idle gaps.
    for (int k = 0; k < 300; k++) begin
      do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge adc_sck); #1;
      end
    end

    repeat (4) @(posedge adc_sck);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, giving the number of 32-bit words of storage (power of two, 4..1024).
REQ-002 SHALL have port adc_sck  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  1  access request, sampled only in IDLE.
REQ-005 SHALL have port we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port store  input  2  store size: 00 word, 01 halfword, 10 byte, 11 treated as word.
REQ-007 SHALL have port addr  input  32  byte address from the CPU ALU result.
REQ-008 SHALL have port wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 SHALL have port rdata  output  32  full aligned word read; sign/zero extension is done by the CPU.
REQ-010 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 SHALL have port err  output  1  misalignment flag, valid with ack.

Function
REQ-013 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, one cycle in each of ACCESS and RESP.
REQ-014 In IDLE with req=1, SHALL latch we, store, addr and wdata, then move to ACCESS; with req=0, SHALL stay in IDLE.
REQ-015 SHALL ignore req while busy=1; a held req SHALL start a new access on the first IDLE cycle after RESP.
REQ-016 SHALL use word index = latched addr[log2(DEPTH)+1:2]; upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
REQ-017 A store SHALL commit in ACCESS, changing only the selected byte lanes:
- byte: lane addr[1:0] gets wdata[7:0];
- half: lanes {addr[1],1} and {addr[1],0} get wdata[15:0];
- word: all lanes get wdata.
REQ-018 A load SHALL read the indexed word in ACCESS and register it to rdata, valid in RESP.
REQ-019 In RESP, ack SHALL be 1 for exactly one cycle; request sampled in cycle N gives ack in cycle N+2.
REQ-020 rdata SHALL hold its last value until the next load's RESP; a store SHALL leave rdata unchanged.
REQ-021 A load issued right after a store to the same word SHALL return the updated data.

Reset
REQ-022 Reset SHALL force IDLE, ack=0, busy=0, err=0 and rdata=0 on the next edge, overriding any state.
REQ-023 Reset asserted in the ACCESS cycle SHALL block the pending store commit; no ack is produced for an aborted access.
REQ-024 Reset SHALL NOT clear the storage array.

Configuration
REQ-025 Macro DMEM_MISALIGN_CHK_EN defined:
- half with addr[0]=1, or word with addr[1:0]!=0, is misaligned;
- a misaligned store writes nothing;
- a misaligned load returns rdata=0;
- both complete with ack=1 and err=1; err=0 on aligned accesses.
REQ-026 Macro not defined:
- err is tied to 0;
- half uses addr[1] only and ignores addr[0];
- word ignores addr[1:0];
- all accesses complete normally.

Verification
REQ-027 Store word 0xDEADBEEF to 0x10, then load 0x10 -> rdata=0xDEADBEEF, ack exactly 2 cycles after each req, err=0.
REQ-028 Word 0x00000000 at 0x20, store byte 0xAB to 0x22 -> a load of 0x20 returns 0x00AB0000; then store half 0x1234 to 0x20 -> returns 0x00AB1234.
REQ-029 DEPTH=64, store word 0x55 to 0x104 -> a load of 0x004 returns 0x00000055 (wrap-around).
REQ-030 Hold req=1 for 6 cycles -> exactly two accesses, ack pulses 3 cycles apart, busy low only on the IDLE cycles.
REQ-031 Store to 0x30 with reset asserted in its ACCESS cycle -> no ack, word 0x30 unchanged, all outputs 0 next cycle.
REQ-032 With DMEM_MISALIGN_CHK_EN, store half to 0x41 -> ack=1, err=1, word 0x40 unchanged; without it -> lanes 1:0 of word 0x40 written, err=0.
